// File: rtl/grid_ad7490_pkg.sv
// Shared constants and types for the AD7490 SPI-slave responder.
// Bit positions refer to the 16-bit control word shifted in on DIN.
package grid_ad7490_pkg;

   localparam int unsigned DinWrite  = 15;
   localparam int unsigned DinSeq    = 14;
   localparam int unsigned DinAddMsb = 13;
   localparam int unsigned DinAddLsb = 10;
   localparam int unsigned DinRange  = 5;
   localparam int unsigned DinCoding = 4;

   // ctrl_word holds DIN[15:4], so its bit 0 is DIN bit 4.
   localparam int unsigned CtrlLsb    = 4;
   localparam int unsigned CtrlCoding = DinCoding - CtrlLsb;

   localparam int unsigned FrameLen = 16;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } resp_state_e;

endpackage

// File: rtl/grid_sync_edge.sv
// Two-flop synchronizer with registered single-cycle rise/fall pulses.
// While reset is held, the edge history tracks the input so release never fakes an edge.
module grid_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk_i) begin
      meta_q <= d_i;
      sync_q <= meta_q;
      if (rst_i) begin
         prev_q <= meta_q;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/grid_ad7490_responder.sv
// AD7490-compatible SPI slave: returns {cur_addr, bank[cur_addr]} each frame and latches DIN.
// Optional GRID_AD7490_RESP_CODING_EN: invert sample bit 11 when ctrl_word CODING = 0.
module grid_ad7490_responder
   import grid_ad7490_pkg::*;
(
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [3:0]  asi_smp_channel,
   input  logic [15:0] asi_smp_data,
   input  logic        asi_smp_valid,
   output logic        asi_smp_ready,
   input  logic        coe_SCLK,
   input  logic        coe_CSN,
   input  logic        coe_DIN,
   output logic        coe_DOUT,
   output logic [11:0] ctrl_word,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam logic [4:0] FrameLenCnt = 5'(FrameLen);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic csn_sync, csn_rise, csn_fall;
   logic din_meta_q, din_sync_q;

   grid_sync_edge u_sync_sclk (
      .clk_i  (csi_MCLK_clk),
      .rst_i  (rsi_MRST_reset),
      .d_i    (coe_SCLK),
      .q_o    (sclk_sync),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   grid_sync_edge u_sync_csn (
      .clk_i  (csi_MCLK_clk),
      .rst_i  (rsi_MRST_reset),
      .d_i    (coe_CSN),
      .q_o    (csn_sync),
      .rise_o (csn_rise),
      .fall_o (csn_fall)
   );

   always_ff @(posedge csi_MCLK_clk) begin
      din_meta_q <= coe_DIN;
      din_sync_q <= din_meta_q;
   end

   resp_state_e state_q, state_d;
   logic        load_tx, shift_en, abort;

   logic [11:0] bank_q [16];
   logic [3:0]  cur_addr_q;
   logic [11:0] ctrl_word_q;
   logic [15:0] frame_cnt_q;
   logic [15:0] tx_q;
   logic [15:0] rx_q;
   logic [4:0]  bit_cnt_q;
   logic        dout_q;
   logic        frame_err_q;
   logic [11:0] tx_sample;

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_tx  = 1'b0;
      shift_en = 1'b0;
      abort    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (csn_fall) begin
               load_tx = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            if (csn_rise) begin
               if (bit_cnt_q >= FrameLenCnt) begin
                  state_d = StDone;
               end else begin
                  abort   = 1'b1;
                  state_d = StIdle;
               end
            end else if (sclk_fall && (bit_cnt_q < FrameLenCnt)) begin
               shift_en = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Bank read is the registered value, so a same-cycle sink write is seen only next frame.
   always_comb begin
      tx_sample = bank_q[cur_addr_q];
`ifdef GRID_AD7490_RESP_CODING_EN
      if (!ctrl_word_q[CtrlCoding]) begin
         tx_sample[11] = ~tx_sample[11];
      end
`endif
   end

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         for (int i = 0; i < 16; i++) begin
            bank_q[i] <= '0;
         end
         cur_addr_q  <= '0;
         ctrl_word_q <= '0;
         frame_cnt_q <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         dout_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= abort;

         if (asi_smp_valid) begin
            bank_q[asi_smp_channel] <= asi_smp_data[15:4];
         end

         if (load_tx) begin
            tx_q      <= {cur_addr_q, tx_sample};
            dout_q    <= cur_addr_q[3];
            bit_cnt_q <= '0;
         end else if (shift_en) begin
            rx_q      <= {rx_q[14:0], din_sync_q};
            tx_q      <= {tx_q[14:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            dout_q    <= (bit_cnt_q == FrameLenCnt - 5'd1) ? 1'b0 : tx_q[14];
         end

         if (abort) begin
            dout_q <= 1'b0;
         end

         if (state_q == StDone) begin
            dout_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (rx_q[DinWrite]) begin
               cur_addr_q  <= rx_q[DinAddMsb:DinAddLsb];
               ctrl_word_q <= rx_q[15:CtrlLsb];
            end
         end
      end
   end

   // SEQ, PM, SHADOW, WEAKTRI, RANGE only ride along in ctrl_word.
   logic unused_sig;
   assign unused_sig = ^{sclk_sync, sclk_rise, csn_sync, asi_smp_data[3:0], rx_q[3:0]};

   assign asi_smp_ready = ~rsi_MRST_reset;
   assign coe_DOUT      = dout_q;
   assign ctrl_word     = ctrl_word_q;
   assign frame_done    = (state_q == StDone);
   assign frame_err     = frame_err_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/grid_ad7490_responder.md
# grid_ad7490_responder

SPI-slave responder for the AD7490 16-bit framed protocol. It lets FPGA-side logic stand in for a physical AD7490, either to serve as a loop-back target for the ADC master during board bring-up or to expose synthetic channel data to an external controller. Channel values arrive on an Avalon-ST sink and are stored in a 16×12 sample bank. Each SPI frame returns the channel addressed in the previous frame, and the incoming control word is decoded and latched.

## Interface
- No parameters.
- csi_MCLK_clk  in  1  sole clock. All SPI pins are oversampled in this domain.
- rsi_MRST_reset  in  1  synchronous, active-high reset.
- asi_smp_channel  in  4  bank index to write.
- asi_smp_data  in  16  sample value, left-justified. Bits 15:4 are stored and bits 3:0 are ignored.
- asi_smp_valid  in  1  sample write strobe.
- asi_smp_ready  out  1  sink ready.
- coe_SCLK  in  1  SPI clock. Idles high.
- coe_CSN  in  1  chip select, active low.
- coe_DIN  in  1  control bits from the master.
- coe_DOUT  out  1  response bits to the master.
- ctrl_word  out  12  last committed DIN[15:4].
- frame_done  out  1  one-cycle pulse when a frame commits.
- frame_err  out  1  one-cycle pulse when a frame aborts.
- frame_cnt  out  16  number of committed frames. Wraps at 0xFFFF→0.

## Operation
- **Input capture:** SCLK, CSN and DIN each pass through a 2-FF synchronizer. Edges are then detected on the synchronized copies.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - coe_DOUT = 0.
  - A CSN falling edge loads the TX shift register with {cur_addr, bank[cur_addr]}, drives bit 15 onto DOUT, clears the bit counter and moves to SHIFT.
- **SHIFT, per SCLK falling edge:**
  - Shift the synchronized DIN into the RX register.
  - Increment the bit counter.
  - On the following cycle, advance DOUT to the next TX bit.
  - After the 16th falling edge, DOUT = 0 and any further edges are ignored.
- **CSN rising edge in SHIFT:**
  - With exactly 16 or more bits received: go to DONE.
  - With fewer than 16 bits received: pulse frame_err, leave all state unchanged, return to IDLE.
- **DONE (1 cycle):**
  - If RX[15] (WRITE) = 1: cur_addr ← RX[13:10] and ctrl_word ← RX[15:4].
  - If WRITE = 0: ctrl_word and cur_addr are kept.
  - Pulse frame_done, increment frame_cnt, return to IDLE.
- **DIN bit map:** 15 WRITE, 14 SEQ, 13:10 ADD, 9:8 PM, 7 SHADOW, 6 WEAKTRI, 5 RANGE, 4 CODING, 3:0 don't-care. SEQ, PM, SHADOW and WEAKTRI are stored in ctrl_word only and have no effect on behaviour.
- **DOUT map:** 15:12 channel ID, 11:0 sample. Sent MSB first.
- **Sample sink:**
  - asi_smp_ready = 1 whenever not in reset.
  - valid=1 writes bank[channel] ← data[15:4].
  - If a bank write and a TX load hit the same entry in the same cycle, the TX load takes the old value (read-before-write).
- **Reset values:**
  - bank all 0, cur_addr 0, ctrl_word 0x000, frame_cnt 0.
  - DOUT 0, frame_done 0, frame_err 0, asi_smp_ready 0.
  - State IDLE.
- **Reset mid-frame:** the frame is discarded and no error pulse is issued. The next CSN falling edge starts a fresh frame.

## Timing
- CSN fall to DOUT bit 15 valid: 4 MCLK cycles (2 synchronizer + edge detect + register).
- SCLK fall to next DOUT bit: 4 MCLK cycles.
- CSN rise to frame_done or frame_err pulse: 4 MCLK cycles.
- Requirement: MCLK ≥ 8 × SCLK frequency. Each SCLK phase must be ≥ 4 MCLK cycles so that DOUT is stable before the master samples on the SCLK falling edge.
- The master must hold CSN high ≥ 4 MCLK cycles between frames. A shorter gap is undefined.

## Configuration
- GRID_AD7490_RESP_CODING_EN
  - Defined: when ctrl_word CODING (bit 4 of DIN, ctrl_word[0]) = 0, the outgoing sample has bit 11 inverted (two's-complement coding). When CODING = 1, the sample is sent as straight binary.
  - Undefined: samples are always sent straight binary and CODING is stored only.

## Structure
- Package grid_ad7490_pkg holds:
  - DIN bit-position constants (WRITE=15, SEQ=14, ADD_MSB=13, ADD_LSB=10, RANGE=5, CODING=4).
  - Frame length constant of 16.
  - Typedef for the state enum.
- One sub-module, grid_sync_edge: a 2-FF synchronizer with registered rise and fall pulses. It is instantiated for SCLK and CSN; DIN uses only the synchronizer.

## Test plan
1. **Return data from previously addressed channel:** write ch5 ← 0xABC0 via the sink. Send frame DIN 0x9710, then send 0x9710 again. Frame 1 DOUT = 0x0000 (ch0 after reset). Frame 2 DOUT = 0x5ABC. ctrl_word = 0x971.
2. **WRITE=0 keeps address and control:** after test 1, send DIN 0x0000. DOUT = 0x5ABC. cur_addr stays 5, ctrl_word stays 0x971, frame_cnt = 3.
3. **Abort on short frame:** raise CSN after 7 SCLK falling edges. frame_err pulses once, frame_cnt is unchanged, and the next full frame still returns ch5.
4. **Read-before-write collision:** bank ch5 = 0x123. Send a sink write of ch5 ← 0x4560 in the same cycle as the TX load. DOUT = 0x5123, and the following frame returns 0x5456.
5. **Coding option (macro defined):** ch5 = 0xABC. Send DIN 0x9700 (CODING=0), then 0x9700 again. Frame 2 DOUT = 0x52BC. With the macro undefined, frame 2 DOUT = 0x5ABC.
6. **Reset mid-frame:** assert reset after 9 SCLK falling edges. DOUT = 0, frame_err is not pulsed, and the next frame returns 0x0000.
